// File: rtl/mips_load_pkg.sv
// Shared encodings for the MIPS load/writeback block: load opcodes, FSM states
// and the legality rule that decides whether a load may issue at all.
package mips_load_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;

  typedef enum logic [2:0] {
    OP_LB   = 3'b000,
    OP_LBU  = 3'b001,
    OP_LH   = 3'b010,
    OP_LHU  = 3'b011,
    OP_LW   = 3'b100,
    OP_LWL  = 3'b101,
    OP_LWR  = 3'b110,
    OP_RSVD = 3'b111
  } load_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_WRITE,
    ST_ERR
  } state_e;

  // Halfwords must sit on even offsets, words on offset 0; LWL/LWR take any offset.
  function automatic logic is_illegal(input load_op_e op, input logic [1:0] k);
    logic bad;
    bad = 1'b0;
    case (op)
      OP_RSVD:        bad = 1'b1;
      OP_LH, OP_LHU:  bad = k[0];
      OP_LW:          bad = (k != 2'd0);
      default:        bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mips_load_align.sv
// Combinational lane steering for big-endian loads: picks the byte/halfword or
// merge window out of the memory word and produces the register byte enables.
module mips_load_align
  import mips_load_pkg::*;
(
  input  load_op_e            op,
  input  logic [1:0]          k,
  input  logic [DATA_W-1:0]   rdata,
  output logic [DATA_W-1:0]   data,
  output logic [BE_W-1:0]     byte_en,
  output logic                illegal
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;
  logic [4:0]  lwl_shift;
  logic [4:0]  lwr_shift;

  // Byte k=0 is the most significant lane of the big-endian word.
  always_comb begin
    sel_byte = 8'h00;
    case (k)
      2'd0:    sel_byte = rdata[31:24];
      2'd1:    sel_byte = rdata[23:16];
      2'd2:    sel_byte = rdata[15:8];
      default: sel_byte = rdata[7:0];
    endcase
  end

  assign sel_half  = k[1] ? rdata[15:0] : rdata[31:16];
  assign lwl_shift = {k, 3'b000};
  // 3-k on a 2-bit offset is its bitwise complement.
  assign lwr_shift = {~k, 3'b000};
  assign illegal   = is_illegal(op, k);

  // NOTE: every output gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis would infer a latch to hold the old value.
  always_comb begin
    data    = '0;
    byte_en = '0;
    if (!illegal) begin
      case (op)
        OP_LB: begin
          data    = {{24{sel_byte[7]}}, sel_byte};
          byte_en = 4'b1111;
        end
        OP_LBU: begin
          data    = {24'h000000, sel_byte};
          byte_en = 4'b1111;
        end
        OP_LH: begin
          data    = {{16{sel_half[15]}}, sel_half};
          byte_en = 4'b1111;
        end
        OP_LHU: begin
          data    = {16'h0000, sel_half};
          byte_en = 4'b1111;
        end
        OP_LW: begin
          data    = rdata;
          byte_en = 4'b1111;
        end
        OP_LWL: begin
          data    = rdata << lwl_shift;
          byte_en = 4'b1111 << k;
        end
        OP_LWR: begin
          data    = rdata >> lwr_shift;
          byte_en = 4'b1111 >> ~k;
        end
        default: begin
          data    = '0;
          byte_en = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/mips_load_writeback.sv
// Load writeback controller: accepts one load at a time, waits for the memory
// word with a bounded timeout, and emits a single-cycle register-file write.
module mips_load_writeback
  import mips_load_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                Clk,
  input  logic                Rst_n,
  input  logic                Load_valid,
  output logic                Load_ready,
  input  logic [2:0]          Load_op,
  input  logic [1:0]          Load_addr_lo,
  input  logic [4:0]          Load_rd,
  input  logic [DATA_W-1:0]   Mem_rdata,
  input  logic                Mem_rvalid,
  output logic [4:0]          Rd_addr,
  output logic [DATA_W-1:0]   Rd_in,
  output logic [BE_W-1:0]     Rd_write_byte_en,
  output logic                Addr_err,
  output logic                Timeout_err
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

  state_e              state_q, state_d;
  load_op_e            op_q;
  logic [1:0]          k_q;
  logic [4:0]          rd_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W-1:0]   data_q;
  logic [BE_W-1:0]     en_q;
  logic                timeout_q;

  load_op_e            align_op;
  logic [1:0]          align_k;
  logic [DATA_W-1:0]   align_data;
  logic [BE_W-1:0]     align_en;
  logic                align_illegal;
  logic                accept;
  logic                timeout_hit;

  // In IDLE the aligner judges the incoming request; afterwards it works on
  // the captured fields so the legality check and the lane steering share it.
  assign align_op = (state_q == ST_IDLE) ? load_op_e'(Load_op) : op_q;
  assign align_k  = (state_q == ST_IDLE) ? Load_addr_lo : k_q;

  mips_load_align u_align (
    .op      (align_op),
    .k       (align_k),
    .rdata   (Mem_rdata),
    .data    (align_data),
    .byte_en (align_en),
    .illegal (align_illegal)
  );

  assign accept      = (state_q == ST_IDLE) && Load_valid;
  // A response in the last allowed WAIT cycle still wins over the timeout.
  assign timeout_hit = (state_q == ST_WAIT) && !Mem_rvalid && (cnt_q == LAST_CNT);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (Load_valid) state_d = align_illegal ? ST_ERR : ST_WAIT;
      ST_WAIT: begin
        if (Mem_rvalid)       state_d = ST_WRITE;
        else if (timeout_hit) state_d = ST_IDLE;
      end
      ST_WRITE: state_d = ST_IDLE;
      ST_ERR:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values, regardless of the order the statements appear in.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_LB;
      k_q       <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
      en_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timeout_q <= timeout_hit;

      if (accept) begin
        op_q <= load_op_e'(Load_op);
        k_q  <= Load_addr_lo;
        rd_q <= Load_rd;
      end

      cnt_q <= (state_q == ST_WAIT) ? cnt_q + CNT_W'(1) : '0;

      if ((state_q == ST_WAIT) && Mem_rvalid) begin
        data_q <= align_data;
        en_q   <= align_en;
      end
    end
  end

  // Writes to $zero are suppressed only through the enables.
  always_comb begin
    Load_ready       = (state_q == ST_IDLE);
    Addr_err         = (state_q == ST_ERR);
    Timeout_err      = timeout_q;
    Rd_addr          = '0;
    Rd_in            = '0;
    Rd_write_byte_en = '0;
    if (state_q == ST_WRITE) begin
      Rd_addr          = rd_q;
      Rd_in            = data_q;
      Rd_write_byte_en = (rd_q == 5'd0) ? '0 : en_q;
    end
  end

endmodule

// File: tb/tb_mips_load_writeback.sv
// Directed bench for mips_load_writeback: a table of loads with hand-computed
// results plus sequences for timeout, reset abort and ignored handshakes.
module tb_mips_load_writeback;

  logic        Clk;
  logic        Rst_n;
  logic        Load_valid;
  logic        Load_ready;
  logic [2:0]  Load_op;
  logic [1:0]  Load_addr_lo;
  logic [4:0]  Load_rd;
  logic [31:0] Mem_rdata;
  logic        Mem_rvalid;
  logic [4:0]  Rd_addr;
  logic [31:0] Rd_in;
  logic [3:0]  Rd_write_byte_en;
  logic        Addr_err;
  logic        Timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [2:0]  op;
    logic [1:0]  k;
    logic [4:0]  rd;
    logic [31:0] rdata;
    int          delay;
    logic        err;
    logic [31:0] exp_data;
    logic [3:0]  exp_en;
  } vec_t;

  vec_t vecs[$];

  mips_load_writeback #(.TIMEOUT(4)) dut (
    .Clk              (Clk),
    .Rst_n            (Rst_n),
    .Load_valid       (Load_valid),
    .Load_ready       (Load_ready),
    .Load_op          (Load_op),
    .Load_addr_lo     (Load_addr_lo),
    .Load_rd          (Load_rd),
    .Mem_rdata        (Mem_rdata),
    .Mem_rvalid       (Mem_rvalid),
    .Rd_addr          (Rd_addr),
    .Rd_in            (Rd_in),
    .Rd_write_byte_en (Rd_write_byte_en),
    .Addr_err         (Addr_err),
    .Timeout_err      (Timeout_err)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_quiet(input string tag, input logic exp_ready);
    check({tag, " en"},    32'(Rd_write_byte_en), 32'h0);
    check({tag, " data"},  Rd_in, 32'h0);
    check({tag, " addr"},  32'(Rd_addr), 32'h0);
    check({tag, " ready"}, 32'(Load_ready), 32'(exp_ready));
  endtask

  function automatic vec_t mk(input logic [2:0] op, input logic [1:0] k, input logic [4:0] rd,
                              input logic [31:0] rdata, input int delay, input logic err,
                              input logic [31:0] d, input logic [3:0] en);
    vec_t v;
    v.op = op; v.k = k; v.rd = rd; v.rdata = rdata; v.delay = delay;
    v.err = err; v.exp_data = d; v.exp_en = en;
    return v;
  endfunction

  // Issues one request from IDLE (called on a falling edge) and checks it end to end.
  task automatic run_vec(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("v%0d", idx);
    check({tag, " ready_idle"}, 32'(Load_ready), 32'h1);
    Load_valid   = 1'b1;
    Load_op      = v.op;
    Load_addr_lo = v.k;
    Load_rd      = v.rd;
    @(negedge Clk);
    Load_valid = 1'b0;
    if (v.err) begin
      check({tag, " addr_err"}, 32'(Addr_err), 32'h1);
      check({tag, " err_en"},   32'(Rd_write_byte_en), 32'h0);
      check({tag, " err_busy"}, 32'(Load_ready), 32'h0);
      @(negedge Clk);
      check({tag, " addr_err_end"}, 32'(Addr_err), 32'h0);
      check({tag, " ready_after"},  32'(Load_ready), 32'h1);
    end else begin
      check({tag, " busy"}, 32'(Load_ready), 32'h0);
      repeat (v.delay) @(negedge Clk);
      Mem_rvalid = 1'b1;
      Mem_rdata  = v.rdata;
      @(negedge Clk);
      Mem_rvalid = 1'b0;
      Mem_rdata  = 32'h5A5A_5A5A;
      check({tag, " data"}, Rd_in, v.exp_data);
      check({tag, " en"},   32'(Rd_write_byte_en), 32'(v.exp_en));
      check({tag, " addr"}, 32'(Rd_addr), 32'(v.rd));
      @(negedge Clk);
      check_quiet({tag, " after"}, 1'b1);
      check({tag, " tmo"}, 32'(Timeout_err), 32'h0);
    end
  endtask

  initial begin
    Rst_n        = 1'b0;
    Load_valid   = 1'b0;
    Load_op      = 3'b000;
    Load_addr_lo = 2'd0;
    Load_rd      = 5'd0;
    Mem_rdata    = 32'h0;
    Mem_rvalid   = 1'b0;

    vecs.push_back(mk(3'b000, 2'd1, 5'd5,  32'h12F45678, 0, 1'b0, 32'hFFFFFFF4, 4'b1111));
    vecs.push_back(mk(3'b001, 2'd1, 5'd5,  32'h12F45678, 1, 1'b0, 32'h000000F4, 4'b1111));
    vecs.push_back(mk(3'b001, 2'd2, 5'd6,  32'h12F45678, 0, 1'b0, 32'h00000056, 4'b1111));
    vecs.push_back(mk(3'b000, 2'd0, 5'd3,  32'h80000000, 2, 1'b0, 32'hFFFFFF80, 4'b1111));
    vecs.push_back(mk(3'b000, 2'd3, 5'd2,  32'h0000007F, 0, 1'b0, 32'h0000007F, 4'b1111));
    vecs.push_back(mk(3'b010, 2'd2, 5'd1,  32'h1234ABCD, 0, 1'b0, 32'hFFFFABCD, 4'b1111));
    vecs.push_back(mk(3'b011, 2'd0, 5'd1,  32'h1234ABCD, 3, 1'b0, 32'h00001234, 4'b1111));
    vecs.push_back(mk(3'b100, 2'd0, 5'd31, 32'hDEADBEEF, 1, 1'b0, 32'hDEADBEEF, 4'b1111));
    vecs.push_back(mk(3'b101, 2'd2, 5'd7,  32'hAABBCCDD, 0, 1'b0, 32'hCCDD0000, 4'b1100));
    vecs.push_back(mk(3'b101, 2'd0, 5'd7,  32'hAABBCCDD, 0, 1'b0, 32'hAABBCCDD, 4'b1111));
    vecs.push_back(mk(3'b101, 2'd3, 5'd8,  32'hAABBCCDD, 2, 1'b0, 32'hDD000000, 4'b1000));
    vecs.push_back(mk(3'b110, 2'd1, 5'd7,  32'hAABBCCDD, 0, 1'b0, 32'h0000AABB, 4'b0011));
    vecs.push_back(mk(3'b110, 2'd0, 5'd9,  32'hAABBCCDD, 0, 1'b0, 32'h000000AA, 4'b0001));
    vecs.push_back(mk(3'b110, 2'd3, 5'd9,  32'hAABBCCDD, 1, 1'b0, 32'hAABBCCDD, 4'b1111));
    vecs.push_back(mk(3'b100, 2'd0, 5'd0,  32'h11112345, 0, 1'b0, 32'h11112345, 4'b0000));
    vecs.push_back(mk(3'b010, 2'd1, 5'd4,  32'h0,        0, 1'b1, 32'h0,        4'b0000));
    vecs.push_back(mk(3'b011, 2'd3, 5'd4,  32'h0,        0, 1'b1, 32'h0,        4'b0000));
    vecs.push_back(mk(3'b100, 2'd2, 5'd4,  32'h0,        0, 1'b1, 32'h0,        4'b0000));
    vecs.push_back(mk(3'b111, 2'd0, 5'd4,  32'h0,        0, 1'b1, 32'h0,        4'b0000));

    #12;
    check_quiet("reset", 1'b1);
    check("reset addr_err", 32'(Addr_err), 32'h0);
    check("reset tmo",      32'(Timeout_err), 32'h0);
    @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);

    // Stray memory response while idle must not produce a write.
    Mem_rvalid = 1'b1;
    Mem_rdata  = 32'hCAFEF00D;
    @(negedge Clk);
    Mem_rvalid = 1'b0;
    check_quiet("idle_rvalid", 1'b1);

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Timeout: four WAIT cycles with no response, then a one-cycle pulse.
    Load_valid = 1'b1; Load_op = 3'b100; Load_addr_lo = 2'd0; Load_rd = 5'd9;
    @(negedge Clk);
    Load_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check($sformatf("tmo wait%0d pulse", c), 32'(Timeout_err), 32'h0);
      check($sformatf("tmo wait%0d busy", c),  32'(Load_ready), 32'h0);
      @(negedge Clk);
    end
    check("tmo pulse", 32'(Timeout_err), 32'h1);
    check_quiet("tmo idle", 1'b1);
    Mem_rvalid = 1'b1;
    Mem_rdata  = 32'h0BADF00D;
    @(negedge Clk);
    Mem_rvalid = 1'b0;
    check("tmo pulse_end", 32'(Timeout_err), 32'h0);
    check_quiet("tmo late_rvalid", 1'b1);

    // Load_valid held through WAIT/WRITE with a different rd is ignored.
    Load_valid = 1'b1; Load_op = 3'b001; Load_addr_lo = 2'd3; Load_rd = 5'd12;
    @(negedge Clk);
    Load_rd = 5'd20; Load_op = 3'b111;
    check("hold busy", 32'(Load_ready), 32'h0);
    Mem_rvalid = 1'b1;
    Mem_rdata  = 32'h000000E1;
    @(negedge Clk);
    Mem_rvalid = 1'b0;
    Load_valid = 1'b0;
    check("hold data", Rd_in, 32'h000000E1);
    check("hold addr", 32'(Rd_addr), 32'd12);
    check("hold addr_err", 32'(Addr_err), 32'h0);
    @(negedge Clk);
    check_quiet("hold after", 1'b1);

    // Reset in WAIT aborts the load; the later response writes nothing.
    Load_valid = 1'b1; Load_op = 3'b100; Load_addr_lo = 2'd0; Load_rd = 5'd4;
    @(negedge Clk);
    Load_valid = 1'b0;
    Rst_n = 1'b0;
    #1;
    check_quiet("rst_wait", 1'b1);
    @(negedge Clk);
    Rst_n = 1'b1;
    Mem_rvalid = 1'b1;
    Mem_rdata  = 32'h77777777;
    @(negedge Clk);
    Mem_rvalid = 1'b0;
    check_quiet("rst_wait late", 1'b1);

    // Reset during WRITE drops the write immediately.
    Load_valid = 1'b1; Load_op = 3'b100; Load_addr_lo = 2'd0; Load_rd = 5'd15;
    @(negedge Clk);
    Load_valid = 1'b0;
    Mem_rvalid = 1'b1;
    Mem_rdata  = 32'h13572468;
    @(negedge Clk);
    Mem_rvalid = 1'b0;
    check("rst_write pre_en", 32'(Rd_write_byte_en), 32'hF);
    Rst_n = 1'b0;
    #1;
    check_quiet("rst_write", 1'b1);
    @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);
    check_quiet("rst_write after", 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
